// File: rtl/lc3_pkg.sv
// lc3_pkg: opcodes, datapath mux selects, control word and FSM states shared by the LC-3 core.
package lc3_pkg;
   localparam logic [3:0] OP_BR = 4'h0, OP_ADD = 4'h1, OP_LD = 4'h2, OP_ST = 4'h3,
                          OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7,
                          OP_RTI = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI = 4'hB,
                          OP_JMP = 4'hC, OP_RES = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF;
   typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_NOT, ALU_PASS} aluk_t;
   typedef enum logic {A1_PC, A1_SR1} addr1_t;
   typedef enum logic [1:0] {A2_ZERO, A2_OFF6, A2_OFF9, A2_OFF11} addr2_t;
   typedef enum logic [1:0] {PC_INC, PC_ADDR, PC_MDR} pcmux_t;
   typedef enum logic {DR_IR, DR_R7} drmux_t;
   typedef enum logic {SR1_MID, SR1_HI} sr1mux_t;
   typedef enum logic [1:0] {REG_ALU, REG_MDR, REG_ADDR, REG_PC} regmux_t;
   typedef enum logic [1:0] {MAR_ADDR, MAR_ZEXT, MAR_MDR} marmux_t;
   typedef enum logic [4:0] {
      S_F1, S_F2, S_F3, S_DEC, S_ALU, S_BR, S_JMP, S_JSR, S_LEA, S_MARPC, S_MARB,
      S_IND1, S_IND2, S_RD, S_LDW, S_STM, S_WR, S_TRAP1, S_TRAP2, S_TRAP3, S_HALT
   } state_t;
   // All-zero control word is a do-nothing cycle.
   typedef struct packed {
      logic    ld_pc, ld_mar, ld_mdr, ld_ir, ld_reg, ld_cc, ld_ben, mio_en, mio_we;
      aluk_t   aluk;
      addr1_t  addr1;
      addr2_t  addr2;
      pcmux_t  pcmux;
      drmux_t  drmux;
      sr1mux_t sr1mux;
      regmux_t regmux;
      marmux_t marmux;
   } ctrl_t;
endpackage

// File: rtl/lc3_alu.sv
// lc3_alu: combinational LC-3 ALU (add, and, not, pass A).
module lc3_alu
   import lc3_pkg::*;
(
   input  aluk_t       aluk,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] y
);
   assign y = aluk == ALU_ADD ? a + b : aluk == ALU_AND ? a & b : aluk == ALU_NOT ? ~a : a;
endmodule

// File: rtl/lc3_mio.sv
// lc3_mio: word memory with a fixed-latency ready handshake and a reset-time program-load port.
module lc3_mio #(
   parameter int MEM_AW  = 16,
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        we,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        ready,
   input  logic        prog_we,
   input  logic [15:0] prog_addr,
   input  logic [15:0] prog_data
);
   logic [15:0] mem [2**MEM_AW];
   logic [2:0]  cnt;
   assign ready = en && cnt == 3'(MEM_LAT);
   assign rdata = mem[addr[MEM_AW-1:0]];
   always_ff @(posedge clk)
      cnt <= (reset || !en || ready) ? 3'd0 : cnt + 3'd1;
   // Contents are never cleared; reset only gates the CPU write port off.
   always_ff @(posedge clk)
      if (reset) begin
         if (prog_we) mem[prog_addr[MEM_AW-1:0]] <= prog_data;
      end else if (en && we && ready) begin
         mem[addr[MEM_AW-1:0]] <= wdata;
      end
endmodule

// File: rtl/lc3_core.sv
// lc3_core: multicycle LC-3 core with microsequenced control FSM, register file and datapath muxes.
module lc3_core
   import lc3_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0200,
   parameter int          MEM_AW   = 16,
   parameter int          MEM_LAT  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        prog_we,
   input  logic [15:0] prog_addr,
   input  logic [15:0] prog_data,
   output logic [15:0] pc,
   output logic [15:0] ir,
   output logic [2:0]  cc,
   output logic        halted
);
   state_t      state, state_n;
   ctrl_t       c;
   logic [15:0] rf [8];
   logic [15:0] mar, mdr, sr1, alu_b, alu_y, a1, a2, addr, rdata, reg_d, pc_d, mar_d;
   logic [3:0]  op;
   logic [2:0]  dr_idx;
   logic        ben, ready;

   assign op     = ir[15:12];
   assign halted = state == S_HALT;
   assign sr1    = rf[c.sr1mux == SR1_HI ? ir[11:9] : ir[8:6]];
   assign alu_b  = ir[5] ? {{11{ir[4]}}, ir[4:0]} : rf[ir[2:0]];
   assign a1     = c.addr1 == A1_PC ? pc : sr1;
   assign a2     = c.addr2 == A2_OFF6 ? {{10{ir[5]}}, ir[5:0]} :
                   c.addr2 == A2_OFF9 ? {{7{ir[8]}}, ir[8:0]} :
                   c.addr2 == A2_OFF11 ? {{5{ir[10]}}, ir[10:0]} : 16'h0000;
   assign addr   = a1 + a2;
   assign dr_idx = c.drmux == DR_R7 ? 3'd7 : ir[11:9];
   assign reg_d  = c.regmux == REG_MDR ? mdr : c.regmux == REG_ADDR ? addr :
                   c.regmux == REG_PC ? pc : alu_y;
   assign pc_d   = c.pcmux == PC_ADDR ? addr : c.pcmux == PC_MDR ? mdr : pc + 16'd1;
   assign mar_d  = c.marmux == MAR_ZEXT ? {8'h00, ir[7:0]} : c.marmux == MAR_MDR ? mdr : addr;

   lc3_alu u_alu (.aluk(c.aluk), .a(sr1), .b(alu_b), .y(alu_y));

   lc3_mio #(.MEM_AW(MEM_AW), .MEM_LAT(MEM_LAT)) u_mio (
      .clk(clk), .reset(reset), .en(c.mio_en), .we(c.mio_we), .addr(mar), .wdata(mdr),
      .rdata(rdata), .ready(ready), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
   );

   always_ff @(posedge clk)
      state <= reset ? S_F1 : state_n;

   always_comb begin
      state_n = state;
      case (state)
         S_F1:    state_n = S_F2;
         S_F2:    state_n = ready ? S_F3 : S_F2;
         S_F3:    state_n = S_DEC;
         S_DEC:
            case (op)
               OP_ADD, OP_AND, OP_NOT:    state_n = S_ALU;
               OP_BR:                     state_n = S_BR;
               OP_JMP:                    state_n = S_JMP;
               OP_JSR:                    state_n = S_JSR;
               OP_LEA:                    state_n = S_LEA;
               OP_LD, OP_ST, OP_LDI, OP_STI: state_n = S_MARPC;
               OP_LDR, OP_STR:            state_n = S_MARB;
               OP_TRAP:                   state_n = S_TRAP1;
               default:                   state_n = S_HALT;
            endcase
         S_MARPC, S_MARB:
            state_n = (op == OP_LDI || op == OP_STI) ? S_IND1 : (op == OP_LD || op == OP_LDR) ? S_RD : S_STM;
         S_IND1:  state_n = ready ? S_IND2 : S_IND1;
         S_IND2:  state_n = op == OP_LDI ? S_RD : S_STM;
         S_RD:    state_n = ready ? S_LDW : S_RD;
         S_STM:   state_n = S_WR;
         S_WR:    state_n = ready ? S_F1 : S_WR;
         S_TRAP1: state_n = S_TRAP2;
         S_TRAP2: state_n = ready ? S_TRAP3 : S_TRAP2;
         S_HALT:  state_n = S_HALT;
         default: state_n = S_F1;
      endcase
   end

   always_comb begin
      c = '0;
      case (state)
         S_F1: begin c.ld_mar = 1'b1; c.ld_pc = 1'b1; end
         S_F2, S_IND1, S_RD, S_TRAP2: begin c.mio_en = 1'b1; c.ld_mdr = ready; end
         S_F3: begin c.ld_ir = 1'b1; c.ld_ben = 1'b1; end
         S_ALU: begin
            c.ld_reg = 1'b1;
            c.ld_cc  = 1'b1;
            c.aluk   = op == OP_ADD ? ALU_ADD : op == OP_AND ? ALU_AND : ALU_NOT;
         end
         S_BR: begin c.ld_pc = ben; c.pcmux = PC_ADDR; c.addr2 = A2_OFF9; end
         S_JMP: begin c.ld_pc = 1'b1; c.pcmux = PC_ADDR; c.addr1 = A1_SR1; end
         // Target comes from the pre-write register file, so JSRR R7 jumps to the old R7.
         S_JSR: begin
            c.ld_pc  = 1'b1;
            c.pcmux  = PC_ADDR;
            c.addr1  = ir[11] ? A1_PC : A1_SR1;
            c.addr2  = ir[11] ? A2_OFF11 : A2_ZERO;
            c.ld_reg = 1'b1;
            c.drmux  = DR_R7;
            c.regmux = REG_PC;
         end
         S_LEA: begin c.ld_reg = 1'b1; c.regmux = REG_ADDR; c.addr2 = A2_OFF9; end
         S_MARPC: begin c.ld_mar = 1'b1; c.addr2 = A2_OFF9; end
         S_MARB: begin c.ld_mar = 1'b1; c.addr1 = A1_SR1; c.addr2 = A2_OFF6; end
         S_IND2: begin c.ld_mar = 1'b1; c.marmux = MAR_MDR; end
         S_LDW: begin c.ld_reg = 1'b1; c.ld_cc = 1'b1; c.regmux = REG_MDR; end
         S_STM: begin c.ld_mdr = 1'b1; c.sr1mux = SR1_HI; c.aluk = ALU_PASS; end
         S_WR: begin c.mio_en = 1'b1; c.mio_we = 1'b1; end
         S_TRAP1: begin
            c.ld_reg = 1'b1;
            c.drmux  = DR_R7;
            c.regmux = REG_PC;
            c.ld_mar = 1'b1;
            c.marmux = MAR_ZEXT;
         end
         S_TRAP3: begin c.ld_pc = 1'b1; c.pcmux = PC_MDR; end
         default: ;
      endcase
   end

   always_ff @(posedge clk)
      if (reset) begin
         pc  <= RESET_PC;
         ir  <= 16'h0000;
         mar <= 16'h0000;
         mdr <= 16'h0000;
         cc  <= 3'b010;
         ben <= 1'b0;
      end else begin
         if (c.ld_pc) pc <= pc_d;
         if (c.ld_ir) ir <= mdr;
         if (c.ld_mar) mar <= mar_d;
         if (c.ld_mdr) mdr <= c.mio_en ? rdata : alu_y;
         if (c.ld_cc) cc <= {reg_d[15], reg_d == 16'h0000, !reg_d[15] && reg_d != 16'h0000};
         if (c.ld_ben) ben <= |(mdr[11:9] & cc);
      end

   always_ff @(posedge clk)
      if (reset) begin
         for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
      end else if (c.ld_reg) begin
         rf[dr_idx] <= reg_d;
      end
endmodule

// File: tb/tb_lc3_core.sv
// tb_lc3_core: runs directed and random LC-3 programs on two cores (memory latency 3 and 0)
// and compares them with an instruction-level reference model.
module tb_lc3_core;
   logic        clk = 1'b0, reset = 1'b1, prog_we = 1'b0;
   logic [15:0] prog_addr = 16'h0000, prog_data = 16'h0000;
   logic [15:0] pc3, ir3, pc0, ir0;
   logic [2:0]  cc3, cc0;
   logic        h3, h0;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   lc3_core #(.RESET_PC(16'h0200), .MEM_AW(10), .MEM_LAT(3)) dut (
      .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .pc(pc3), .ir(ir3), .cc(cc3), .halted(h3)
   );
   lc3_core #(.RESET_PC(16'h0200), .MEM_AW(10), .MEM_LAT(0)) dut0 (
      .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .pc(pc0), .ir(ir0), .cc(cc0), .halted(h0)
   );

   // Reference machine state: 1024-word aliased memory, registers, PC, NZP, access count.
   logic [15:0] m [1024], msave [1024], r [8], mpc;
   logic [2:0]  mcc;
   bit          mhalt;
   int          acc;
   logic [15:0] qa [$], qd [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] rd(input logic [15:0] a);
      acc++;
      return m[a[9:0]];
   endfunction

   function automatic void wr(input logic [15:0] a, input logic [15:0] d);
      acc++;
      m[a[9:0]] = d;
   endfunction

   function automatic void setcc(input logic [15:0] v);
      mcc = v[15] ? 3'b100 : v == 16'h0000 ? 3'b010 : 3'b001;
   endfunction

   task automatic step();
      logic [15:0] ins, v, t, s5, s6, s9, s11;
      logic [2:0]  dr, sr;
      ins = rd(mpc);
      mpc = mpc + 16'd1;
      dr  = ins[11:9];
      sr  = ins[8:6];
      s5  = 16'($signed(ins[4:0]));
      s6  = 16'($signed(ins[5:0]));
      s9  = 16'($signed(ins[8:0]));
      s11 = 16'($signed(ins[10:0]));
      case (ins[15:12])
         4'h1: begin v = r[sr] + (ins[5] ? s5 : r[ins[2:0]]); r[dr] = v; setcc(v); end
         4'h5: begin v = r[sr] & (ins[5] ? s5 : r[ins[2:0]]); r[dr] = v; setcc(v); end
         4'h9: begin v = ~r[sr]; r[dr] = v; setcc(v); end
         4'h0: if (|(ins[11:9] & mcc)) mpc = mpc + s9;
         4'hC: mpc = r[sr];
         4'h4: begin t = ins[11] ? mpc + s11 : r[sr]; r[7] = mpc; mpc = t; end
         4'h2: begin v = rd(mpc + s9); r[dr] = v; setcc(v); end
         4'h6: begin v = rd(r[sr] + s6); r[dr] = v; setcc(v); end
         4'hA: begin v = rd(rd(mpc + s9)); r[dr] = v; setcc(v); end
         4'h3: wr(mpc + s9, r[dr]);
         4'h7: wr(r[sr] + s6, r[dr]);
         4'hB: wr(rd(mpc + s9), r[dr]);
         4'hE: r[dr] = mpc + s9;
         4'hF: begin r[7] = mpc; mpc = rd({8'h00, ins[7:0]}); end
         default: mhalt = 1'b1;
      endcase
   endtask

   task automatic model_run(input int n, output bit done);
      for (int i = 0; i < 8; i++) r[i] = 16'h0000;
      mpc = 16'h0200; mcc = 3'b010; mhalt = 1'b0; acc = 0;
      for (int i = 0; i < n && !mhalt; i++) step();
      done = mhalt;
   endtask

   task automatic load(input logic [15:0] a, input logic [15:0] d);
      m[a[9:0]] = d;
      qa.push_back(a);
      qd.push_back(d);
   endtask

   task automatic apply();
      @(negedge clk);
      reset = 1'b1; prog_we = 1'b0;
      @(negedge clk);
      chk("rst_pc", pc3, 16'h0200);
      chk("rst_ir", ir3, 16'h0000);
      chk("rst_cc", cc3, 3'b010);
      chk("rst_halt", h3, 1'b0);
      while (qa.size() > 0) begin
         prog_we = 1'b1; prog_addr = qa.pop_front(); prog_data = qd.pop_front();
         @(negedge clk);
      end
      prog_we = 1'b0; reset = 1'b0;
   endtask

   task automatic run_cmp(input string tag, input int budget);
      int c3 = 0, c0 = 0, d3 = 0, d0 = 0;
      apply();
      for (int k = 0; k < budget && !(h3 && h0); k++) begin
         @(posedge clk); #1;
         if (!h3) c3++;
         if (!h0) c0++;
      end
      repeat (5) @(posedge clk);
      #1;
      chk({tag, "_halt3"}, h3, mhalt);
      chk({tag, "_halt0"}, h0, mhalt);
      chk({tag, "_pc3"}, pc3, mpc);
      chk({tag, "_pc0"}, pc0, mpc);
      chk({tag, "_cc3"}, cc3, mcc);
      chk({tag, "_cc0"}, cc0, mcc);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s_r%0d", tag, i), dut.rf[i], r[i]);
         chk($sformatf("%s_r%0d_l0", tag, i), dut0.rf[i], r[i]);
      end
      for (int j = 0; j < 1024; j++) begin
         if (dut.u_mio.mem[j] !== m[j]) d3++;
         if (dut0.u_mio.mem[j] !== m[j]) d0++;
      end
      chk({tag, "_mem3"}, d3, 0);
      chk({tag, "_mem0"}, d0, 0);
      // Every access costs MEM_LAT+1 cycles, so latency 3 vs 0 adds 3 per access.
      chk({tag, "_cycdiff"}, c3 - c0, 3 * acc);
   endtask

   initial begin
      bit done;
      for (int j = 0; j < 1024; j++) load(16'(j), 16'($urandom));

      load(16'h0200, 16'h1225); load(16'h0201, 16'hD000);
      model_run(400, done); run_cmp("add", 2000);
      chk("add_r1", dut.rf[1], 16'h0005); chk("add_cc", cc3, 3'b001); chk("add_pc", pc3, 16'h0202);

      load(16'h0200, 16'h1225); load(16'h0201, 16'h5460); load(16'h0202, 16'hD000);
      model_run(400, done); run_cmp("and", 2000);
      chk("and_r1", dut.rf[1], 16'h0005); chk("and_r2", dut.rf[2], 16'h0000); chk("and_cc", cc3, 3'b010);

      load(16'h0200, 16'h903F); load(16'h0201, 16'h0801); load(16'h0202, 16'hD000); load(16'h0203, 16'hD000);
      model_run(400, done); run_cmp("brn", 2000);
      chk("brn_r0", dut.rf[0], 16'hFFFF); chk("brn_cc", cc3, 3'b100); chk("brn_pc", pc3, 16'h0204);

      load(16'h0201, 16'h0201);
      model_run(400, done); run_cmp("brp", 2000);
      chk("brp_pc", pc3, 16'h0203);

      load(16'h0200, 16'h2601); load(16'h0201, 16'hD000); load(16'h0202, 16'h8000);
      model_run(400, done); run_cmp("ld", 2000);
      chk("ld_r3", dut.rf[3], 16'h8000); chk("ld_cc", cc3, 3'b100);

      load(16'h0200, 16'h2603); load(16'h0201, 16'h3604); load(16'h0202, 16'hEA03);
      load(16'h0203, 16'h6940); load(16'h0204, 16'h8000); load(16'h0206, 16'h0000);
      model_run(400, done); run_cmp("stldr", 2000);
      chk("stldr_r4", dut.rf[4], 16'h8000); chk("stldr_pc", pc3, 16'h0205);
      chk("stldr_mem", dut.u_mio.mem[16'h0206], 16'h8000);

      load(16'h0200, 16'h4804); load(16'h0201, 16'hD000); load(16'h0205, 16'hC1C0);
      model_run(400, done); run_cmp("jsr", 2000);
      chk("jsr_r7", dut.rf[7], 16'h0201); chk("jsr_pc", pc3, 16'h0202);

      load(16'h0200, 16'hF025); load(16'h0025, 16'h0300); load(16'h0300, 16'hD000);
      model_run(400, done); run_cmp("trap", 2000);
      chk("trap_r7", dut.rf[7], 16'h0201); chk("trap_pc", pc3, 16'h0301);

      load(16'h0200, 16'h903F); load(16'h0201, 16'hE005); load(16'h0202, 16'hD000);
      model_run(400, done); run_cmp("lea", 2000);
      chk("lea_r0", dut.rf[0], 16'h0207); chk("lea_cc", cc3, 3'b100);

      load(16'h0200, 16'hA202); load(16'h0201, 16'hD000); load(16'h0203, 16'h0210); load(16'h0210, 16'h1234);
      model_run(400, done); run_cmp("ldi", 2000);
      chk("ldi_r1", dut.rf[1], 16'h1234); chk("ldi_cc", cc3, 3'b001);

      load(16'h0200, 16'hD000);
      model_run(400, done); run_cmp("halt", 2000);
      chk("halt_pc", pc3, 16'h0201); chk("halt_flag", h3, 1'b1);
      model_run(400, done); run_cmp("retain", 2000);
      chk("retain_pc", pc3, 16'h0201);

      for (int p = 0; p < 12; p++) begin
         done = 1'b0;
         for (int t = 0; t < 40 && !done; t++) begin
            msave = m;
            qa.delete(); qd.delete();
            for (int i = 0; i < 16; i++) load(16'h0200 + 16'(i), 16'($urandom));
            for (int i = 0; i < 4; i++) load(16'($urandom_range(0, 1023)), 16'($urandom));
            model_run(150, done);
            if (!done) m = msave;
         end
         if (!done) begin
            qa.delete(); qd.delete();
            load(16'h0200, 16'hD000);
            model_run(10, done);
         end
         run_cmp($sformatf("rnd%0d", p), 4000);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
